// File: rtl/mbc_sbus_seq.sv
// SBUS core-memory request sequencer: takes one MBOX request, issues the SBUS start,
// waits for ACKN (real or NXM) and walks the read data words and/or write data strobes.
module mbc_sbus_seq #(
    parameter int unsigned ADR_W    = 22,
    parameter int unsigned DATA_TMO = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rq_valid,
    input  logic             rq_rd,
    input  logic             rq_wr,
    input  logic [ADR_W-1:0] rq_adr,
    input  logic [3:0]       rq_wd_mask,
    output logic             rq_ready,
    input  logic             wr_go,
    input  logic             mem_ack,
    input  logic             mem_data_valid,
    input  logic             nxm_ackn,
    input  logic             nxm_data_val,
    output logic             mem_start_a,
    output logic             mem_start_b,
    output logic             rq_hold_ff,
    output logic             mem_rd_rq,
    output logic             mem_wr_rq,
    output logic [ADR_W-1:0] sbus_adr,
    output logic [3:0]       sbus_rq,
    output logic             ackn_pulse,
    output logic             core_rd_in_prog,
    output logic             core_busy,
    output logic             wr_data_strobe,
    output logic [1:0]       mem_wd_sel,
    output logic             data_tmo
);

    localparam int unsigned TMO_W = $clog2(DATA_TMO + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_ACK,
        RD_PROG,
        PSE,
        WR_DATA
    } state_t;

    state_t           state_q, state_d;
    logic             rd_q, rd_d, wr_q, wr_d;
    logic [1:0]       first_q, first_d;
    logic [2:0]       n_q, n_d, rem_q, rem_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic [ADR_W-1:0] adr_d;
    logic [3:0]       mask_d;
    logic [1:0]       wd_sel_d;
    logic             ackn_d, tmo_d;

    logic             accept, ack_in, word_in;
    logic [3:0]       acc_mask;
    logic [2:0]       acc_n;

    // Lowest-offset word in mask at or after 'from' (incl) or strictly after it, modulo 4.
    function automatic logic [1:0] next_word(input logic [1:0] from, input logic [3:0] mask,
                                             input logic incl);
        logic [1:0] w;
        next_word = from;
        for (int i = 3; i >= 0; i--) begin
            w = from + 2'(i);
            if ((incl || i != 0) && mask[w]) next_word = w;
        end
    endfunction

    // Request decode: effective word mask and word count for an accepted request.
    always_comb begin
        ack_in  = mem_ack | nxm_ackn;
        word_in = mem_data_valid | nxm_data_val;
        accept  = rq_valid & rq_ready & (rq_rd | rq_wr);
        if (rq_wd_mask != 4'b0000) begin
            acc_mask = rq_wd_mask;
        end else if (rq_rd) begin
            acc_mask = 4'b1111;
        end else begin
            acc_mask = 4'b0001 << rq_adr[1:0];
        end
        acc_n = 3'(acc_mask[0]) + 3'(acc_mask[1]) + 3'(acc_mask[2]) + 3'(acc_mask[3]);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        first_d  = first_q;
        n_d      = n_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        adr_d    = sbus_adr;
        mask_d   = sbus_rq;
        wd_sel_d = mem_wd_sel;
        ackn_d   = 1'b0;
        tmo_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = START;
                    rd_d     = rq_rd;
                    wr_d     = rq_wr;
                    adr_d    = rq_adr;
                    mask_d   = acc_mask;
                    n_d      = acc_n;
                    rem_d    = acc_n;
                    first_d  = next_word(rq_adr[1:0], acc_mask, 1'b1);
                    wd_sel_d = first_d;
                end
            end
            START: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack_in) begin
                    ackn_d   = 1'b1;
                    cnt_d    = '0;
                    rem_d    = n_q;
                    wd_sel_d = first_q;
                    state_d  = rd_q ? RD_PROG : WR_DATA;
                end
            end
            RD_PROG: begin
                if (cnt_q == TMO_W'(DATA_TMO)) begin
                    state_d = IDLE;
                end else if (word_in) begin
                    cnt_d = '0;
                    if (rem_q == 3'd1) begin
                        if (!wr_q) begin
                            state_d = IDLE;
                        end else if (wr_go) begin
                            state_d  = WR_DATA;
                            rem_d    = n_q;
                            wd_sel_d = first_q;
                        end else begin
                            state_d = PSE;
                        end
                    end else begin
                        rem_d    = rem_q - 3'd1;
                        wd_sel_d = next_word(mem_wd_sel, sbus_rq, 1'b0);
                    end
                end else begin
                    cnt_d = cnt_q + TMO_W'(1);
                    tmo_d = (cnt_q == TMO_W'(DATA_TMO - 1));
                end
            end
            PSE: begin
                if (wr_go) begin
                    state_d  = WR_DATA;
                    rem_d    = n_q;
                    wd_sel_d = first_q;
                end
            end
            WR_DATA: begin
                if (rem_q == 3'd1) begin
                    state_d = IDLE;
                end else begin
                    rem_d    = rem_q - 3'd1;
                    wd_sel_d = next_word(mem_wd_sel, sbus_rq, 1'b0);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == IDLE) wd_sel_d = 2'b00;
    end

    // State, context and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            rd_q            <= 1'b0;
            wr_q            <= 1'b0;
            first_q         <= 2'b00;
            n_q             <= 3'd0;
            rem_q           <= 3'd0;
            cnt_q           <= '0;
            rq_ready        <= 1'b0;
            mem_start_a     <= 1'b0;
            mem_start_b     <= 1'b0;
            rq_hold_ff      <= 1'b0;
            mem_rd_rq       <= 1'b0;
            mem_wr_rq       <= 1'b0;
            sbus_adr        <= '0;
            sbus_rq         <= 4'b0000;
            ackn_pulse      <= 1'b0;
            core_rd_in_prog <= 1'b0;
            core_busy       <= 1'b0;
            wr_data_strobe  <= 1'b0;
            mem_wd_sel      <= 2'b00;
            data_tmo        <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_q            <= rd_d;
            wr_q            <= wr_d;
            first_q         <= first_d;
            n_q             <= n_d;
            rem_q           <= rem_d;
            cnt_q           <= cnt_d;
            rq_ready        <= (state_d == IDLE);
            mem_start_a     <= (state_d == START);
            mem_start_b     <= (state_d == START) || (state_d == WAIT_ACK);
            rq_hold_ff      <= (state_d == WAIT_ACK);
            mem_rd_rq       <= (state_d != IDLE) && rd_d;
            mem_wr_rq       <= (state_d != IDLE) && wr_d;
            sbus_adr        <= adr_d;
            sbus_rq         <= mask_d;
            ackn_pulse      <= ackn_d;
            core_rd_in_prog <= (state_d == RD_PROG);
            core_busy       <= (state_d != IDLE);
            wr_data_strobe  <= (state_d == WR_DATA);
            mem_wd_sel      <= wd_sel_d;
            data_tmo        <= tmo_d;
        end
    end

endmodule

// File: doc/mbc_sbus_seq.md
Name: mbc_sbus_seq

Overview:
- SBUS core-memory request sequencer; sits directly upstream of the MBZ memory-control/NXM logic.
- Accepts one MBOX core request at a time and issues the SBUS start.
- Produces MEM_START_A/B, RQ_HOLD_FF, ACKN_PULSE, CORE_RD_IN_PROG, MEM_RD_RQ and MEM_WR_RQ.
- Consumes MBZ's NXM_ACKN and NXM_DATA_VAL in place of a real memory acknowledge or data when memory does not respond.

Parameters:
- ADR_W, 22, physical address width (PMA 14:35).
- DATA_TMO, 64, cycles without a data word in a read before the read is abandoned.

Ports:
- clk  in  1  MBOX clock.
- RESET  in  1  asynchronous, active-high reset.
- rq_valid  in  1  MBOX request present.
- rq_rd  in  1  read request.
- rq_wr  in  1  write request; rq_rd and rq_wr together = read-pause-write.
- rq_adr  in  ADR_W  physical address; [1:0] = starting word.
- rq_wd_mask  in  4  quad-word words requested (RQ0-3).
- rq_ready  out  1  sequencer can accept a request.
- wr_go  in  1  MBOX releases the write half of a read-pause-write.
- mem_ack  in  1  SBUS ACKN from memory.
- mem_data_valid  in  1  SBUS read data word present.
- nxm_ackn  in  1  from MBZ; substitutes for mem_ack.
- nxm_data_val  in  1  from MBZ; substitutes for mem_data_valid.
- mem_start_a  out  1  one-cycle start pulse.
- mem_start_b  out  1  start held until acknowledged.
- rq_hold_ff  out  1  request held awaiting acknowledge.
- mem_rd_rq  out  1  latched read request.
- mem_wr_rq  out  1  latched write request.
- sbus_adr  out  ADR_W  latched address.
- sbus_rq  out  4  latched word mask.
- ackn_pulse  out  1  one cycle after acknowledge.
- core_rd_in_prog  out  1  read data words outstanding.
- core_busy  out  1  any cycle in progress.
- wr_data_strobe  out  1  write word driven this cycle.
- mem_wd_sel  out  2  current word number.
- data_tmo  out  1  one-cycle read-timeout pulse.

Behaviour:
- Reset: asynchronous. Every output is 0, FSM = IDLE, counters = 0. Reset mid-operation drops the cycle; no completion or ackn_pulse follows.
- rq_ready = 1 only in IDLE.
- Accept: rq_valid & rq_ready & (rq_rd | rq_wr) latches adr, mask, rd and wr. A request with neither rd nor wr is not accepted and leaves IDLE unchanged.
- Word count N = popcount(mask). A read with mask 0 uses N = 4 and mask 1111. A write with mask 0 uses N = 1 and mask = the one-hot bit of adr[1:0].
- IDLE -> START on accept.
- START, one cycle: mem_start_a = 1, mem_start_b = 1. Next state is WAIT_ACK.
- WAIT_ACK: mem_start_b = 1, rq_hold_ff = 1. On mem_ack | nxm_ackn, the next cycle pulses ackn_pulse and goes to RD_PROG if rd, else WR_DATA. If both arrive in the same cycle, mem_ack wins; outcome is identical.
- RD_PROG: core_rd_in_prog = 1.
  - Each mem_data_valid | nxm_data_val consumes one word; mem_wd_sel shows the word being consumed.
  - Words advance from adr[1:0] upward modulo 4, skipping words not in mask.
  - After the Nth word: go to PSE if wr is latched, else IDLE.
  - Timeout counter clears on each word. When it reaches DATA_TMO, pulse data_tmo and go to IDLE.
- PSE (read-pause-write): core_busy held. wr_go -> WR_DATA. wr_go arriving in the same cycle as the last read word is sampled and goes straight to WR_DATA.
- WR_DATA: wr_data_strobe = 1 for N consecutive cycles, with mem_wd_sel walking as in RD_PROG; then IDLE.
- core_busy = 1 in every state except IDLE.
- mem_rd_rq and mem_wr_rq hold the latched values from START until return to IDLE, then clear.
- Latency: accept at T0; mem_start_a at T1; ack sampled at Tk; ackn_pulse at Tk+1; earliest rq_ready again is the cycle after the last word or strobe.

Test Plan:
- Read adr[1:0]=2, mask=1111, ack at T3, four data_valids -> start_a at T1 only; start_b T1-T3; ackn_pulse at T4; wd_sel 2,3,0,1; rq_ready 1 the cycle after the 4th word.
- Write adr[1:0]=1, mask=0000 -> N=1; one wr_data_strobe with wd_sel=1; mem_wr_rq=1, mem_rd_rq=0 throughout.
- Read with nxm_ackn then four nxm_data_val -> identical sequencing to a real ack; core_rd_in_prog falls after the 4th word.
- Read-pause-write, mask=0101, adr[1:0]=0: two reads (wd_sel 0,2); PSE held 5 cycles; wr_go -> two strobes wd_sel 0,2; core_busy continuous from T1.
- Read with no data after ack, DATA_TMO=64 -> data_tmo pulse 64 cycles after ackn_pulse; next cycle IDLE, rq_ready=1.
- RESET asserted mid WAIT_ACK, and mem_ack arriving in the same cycle as RESET -> outputs 0 immediately; no ackn_pulse afterwards.
